// File: rtl/irq_timer_bank_if.sv
// CPU-side register bus of the interval timer bank: chip select, direction,
// address and data. Read data comes back one cycle after the access.
interface irq_timer_bank_if;
  logic       cs;
  logic       we;
  logic [4:0] addr;
  logic [7:0] din;
  logic [7:0] dout;

  modport master (output cs, we, addr, din, input dout);
  modport slave  (input cs, we, addr, din, output dout);
endinterface

// File: rtl/irq_timer_bank.sv
// Bank of NUM_CH down-counting interval timers sharing one prescaler, with a
// level IRQ built from per-channel status and interrupt enables.
module irq_timer_ch #(
  parameter int WIDTH = 8
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             tick_fast,
  input  logic             tick_slow,
  input  logic             wr_lo,
  input  logic             wr_hi,
  input  logic             wr_ctrl,
  input  logic             ack,
  input  logic [7:0]       din,
  output logic [WIDTH-1:0] count,
  output logic [3:0]       ctrl,
  output logic             status
);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] reload;
  logic [WIDTH-1:0] load_val;
  logic             tick;
  logic             zero_ev;
  logic             expire;

  // Wide counters stage the upper byte; the low-byte write commits the pair.
  if (WIDTH > 8) begin : g_hi
    logic [WIDTH-9:0] hi_latch;
    always_ff @(posedge clk_sys or negedge reset_n)
      if (!reset_n)   hi_latch <= '0;
      else if (wr_hi) hi_latch <= din[WIDTH-9:0];
    assign load_val = {hi_latch, din};
  end else begin : g_lo
    logic unused_hi;
    assign unused_hi = ^{wr_hi, din};
    assign load_val  = din[WIDTH-1:0];
  end

  assign tick    = ctrl[2] ? tick_slow : tick_fast;
  assign zero_ev = wr_lo & ctrl[0] & (load_val == '0);
  assign expire  = ~wr_lo & ctrl[0] & tick & (count == ONE);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      count  <= '0;
      reload <= '0;
    end else if (wr_lo) begin
      count  <= load_val;
      reload <= load_val;
    end else if (ctrl[0] && tick && count != '0) begin
      if (count == ONE) count <= (ctrl[1] && reload != '0) ? reload : '0;
      else              count <= count - ONE;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n)     ctrl <= '0;
    else if (wr_ctrl) ctrl <= din[3:0];

  // A new event outranks an acknowledge landing in the same cycle.
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n)               status <= 1'b0;
    else if (zero_ev || expire) status <= 1'b1;
    else if (ack)               status <= 1'b0;
endmodule

module irq_timer_bank #(
  parameter int NUM_CH      = 4,
  parameter int WIDTH       = 8,
  parameter int FAST_SHIFT  = 8,
  parameter int SLOW_SHIFT  = 14,
  parameter int ACK_ON_READ = 1
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ce,
  irq_timer_bank_if.slave   bus,
  output logic              irq,
  output logic [NUM_CH-1:0] irq_vec
);
  localparam logic [4:0] STAT_ADDR = 5'(4 * NUM_CH);
  localparam logic       RD_ACK    = (ACK_ON_READ != 0);

  logic [SLOW_SHIFT-1:0]           psc;
  logic                            tick_fast, tick_slow;
  logic                            wr, rd, stat_sel;
  logic [NUM_CH-1:0][WIDTH-1:0]    count;
  logic [NUM_CH-1:0][3:0]          ctrl;
  logic [NUM_CH-1:0]               status, ien, ack;
  logic [7:0]                      rdata, dout_q;

  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) psc <= '0;
    else if (ce)  psc <= psc + SLOW_SHIFT'(1);

  assign tick_fast = ce & (psc[FAST_SHIFT-1:0] == '0);
  assign tick_slow = ce & (psc == '0);

  assign wr       = bus.cs & bus.we;
  assign rd       = bus.cs & ~bus.we;
  assign stat_sel = (bus.addr == STAT_ADDR);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic sel;
    assign sel = (bus.addr[4:2] == 3'(i));

    irq_timer_ch #(.WIDTH(WIDTH)) u_ch (
      .clk_sys   (clk_sys),
      .reset_n   (reset_n),
      .tick_fast (tick_fast),
      .tick_slow (tick_slow),
      .wr_lo     (wr & sel & (bus.addr[1:0] == 2'd0)),
      .wr_hi     (wr & sel & (bus.addr[1:0] == 2'd1)),
      .wr_ctrl   (wr & sel & (bus.addr[1:0] == 2'd2)),
      .ack       (ack[i]),
      .din       (bus.din),
      .count     (count[i]),
      .ctrl      (ctrl[i]),
      .status    (status[i])
    );

    assign ien[i] = ctrl[i][3];
    // On a read-ack, only bits that are 1 (and thus land in dout) get cleared.
    assign ack[i] = stat_sel & ((wr & bus.din[i]) | (rd & RD_ACK & status[i]));
  end

  always_comb begin
    logic [15:0] c16;
    rdata = '0;
    c16   = '0;
    if (stat_sel) rdata = 8'(status);
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.addr[4:2] == 3'(i)) begin
        c16 = 16'(count[i]);
        case (bus.addr[1:0])
          2'd0:    rdata = c16[7:0];
          2'd1:    rdata = c16[15:8];
          2'd2:    rdata = {4'd0, ctrl[i]};
          default: rdata = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) dout_q <= '0;
    else if (rd)  dout_q <= rdata;

  assign bus.dout = dout_q;
  assign irq      = |(status & ien);
  assign irq_vec  = status;
endmodule
